// File: rtl/mux_seq_pkg.sv
// Shared types and sizing helpers for the mux loopback sequencer.
//   state_e        : sequencer FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_DATA_W : default mux data width
//   sel_w()        : select width for a given data width
package mux_seq_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Select width; a 1-bit select is the floor for degenerate widths.
   function automatic int unsigned sel_w(input int unsigned data_w);
      return (data_w < 2) ? 1 : $clog2(data_w);
   endfunction

endpackage

// File: rtl/mux_loopback_sequencer_if.sv
// Load handshake plus mux loopback bus between the sequencer and its environment.
//   master : the sequencer (drives mux inputs/select, reports sampled stream and result)
//   slave  : the environment (drives load handshake, abort and the mux output Y)
interface mux_loopback_sequencer_if #(
   parameter int unsigned DATA_W = mux_seq_pkg::DEFAULT_DATA_W
);
   import mux_seq_pkg::*;

   localparam int unsigned SEL_W = sel_w(DATA_W);

   logic              load_valid;
   logic              load_ready;
   logic [DATA_W-1:0] load_data;
   logic              abort;
   logic [DATA_W-1:0] mux_data;
   logic [SEL_W-1:0]  mux_sel;
   logic              mux_y;
   logic              bit_valid;
   logic              bit_out;
   logic              done;
   logic              match;
   logic [DATA_W-1:0] cap_data;

   modport master (
      input  load_valid, load_data, abort, mux_y,
      output load_ready, mux_data, mux_sel, bit_valid, bit_out, done, match, cap_data
   );

   modport slave (
      output load_valid, load_data, abort, mux_y,
      input  load_ready, mux_data, mux_sel, bit_valid, bit_out, done, match, cap_data
   );

endinterface

// File: rtl/mux_loopback_sequencer_sel_counter.sv
// Up/down select counter with synchronous load and enable.
//   clk, rst     : clock, async active-high reset (count clears to 0)
//   load_i       : load load_val_i (priority over enable)
//   load_val_i   : value to load
//   en_i         : step one position in the configured direction
//   cnt_o        : registered count
//   last_o       : count is at the final position for the direction
module sel_counter #(
   parameter int unsigned SEL_W    = 3,
   parameter bit          COUNT_UP = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [SEL_W-1:0] load_val_i,
   input  logic             en_i,
   output logic [SEL_W-1:0] cnt_o,
   output logic             last_o
);

   logic [SEL_W-1:0] cnt_q, cnt_d;

   // Next count: load beats step; no wrap handling needed since the FSM stops at last.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = COUNT_UP ? (cnt_q + SEL_W'(1)) : (cnt_q - SEL_W'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   // Data width is a power of two, so the top select is all ones.
   assign last_o = COUNT_UP ? (&cnt_q) : (~|cnt_q);

endmodule

// File: rtl/mux_loopback_sequencer.sv
// Drives a byte onto an 8-to-1 mux, walks the select through every input, samples Y
// as a serial stream, reassembles it and reports whether the mux returned the byte.
//   clk, rst : clock, async active-high reset
//   bus      : master side of the load handshake / mux loopback interface
//              (load_ready is combinational from state; all other outputs registered)
module mux_loopback_sequencer
   import mux_seq_pkg::*;
#(
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   mux_loopback_sequencer_if.master bus
);

   localparam int unsigned SEL_W = sel_w(DATA_W);
   localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mux_data_q, mux_data_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic              bit_valid_q, bit_valid_d;
   logic              bit_out_q, bit_out_d;
   logic              done_q, done_d;
   logic              match_q, match_d;

   logic              cnt_load_c;
   logic [SEL_W-1:0]  cnt_load_val_c;
   logic              cnt_en_c;
   logic [SEL_W-1:0]  sel_cnt;
   logic              sel_last;
   logic              load_ready_c;

   sel_counter #(
      .SEL_W    (SEL_W),
      .COUNT_UP (!MSB_FIRST)
   ) u_sel_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load_c),
      .load_val_i (cnt_load_val_c),
      .en_i       (cnt_en_c),
      .cnt_o      (sel_cnt),
      .last_o     (sel_last)
   );

   assign load_ready_c = (state_q == IDLE);

   // Next-state, capture and result logic.
   always_comb begin
      state_d        = state_q;
      mux_data_d     = mux_data_q;
      cap_d          = cap_q;
      bit_valid_d    = 1'b0;
      bit_out_d      = bit_out_q;
      done_d         = 1'b0;
      match_d        = match_q;
      cnt_load_c     = 1'b0;
      cnt_load_val_c = '0;
      cnt_en_c       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.load_valid) begin
               mux_data_d     = bus.load_data;
               cap_d          = '0;
               match_d        = 1'b0;
               cnt_load_c     = 1'b1;
               cnt_load_val_c = SEL_START;
               state_d        = SHIFT;
            end
         end
         SHIFT: begin
            // Abort takes priority, including on the last-bit cycle.
            if (bus.abort) begin
               cnt_load_c = 1'b1;
               state_d    = IDLE;
            end else begin
               cap_d[sel_cnt] = bus.mux_y;
               bit_out_d      = bus.mux_y;
               bit_valid_d    = 1'b1;
               if (sel_last) begin
                  // Compare against the capture including the bit landing this edge.
                  done_d  = 1'b1;
                  match_d = (cap_d == mux_data_q);
                  state_d = DONE;
               end else begin
                  cnt_en_c = 1'b1;
               end
            end
         end
         DONE: begin
            cnt_load_c = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            cnt_load_c = 1'b1;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mux_data_q  <= '0;
         cap_q       <= '0;
         bit_valid_q <= 1'b0;
         bit_out_q   <= 1'b0;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mux_data_q  <= mux_data_d;
         cap_q       <= cap_d;
         bit_valid_q <= bit_valid_d;
         bit_out_q   <= bit_out_d;
         done_q      <= done_d;
         match_q     <= match_d;
      end
   end

   assign bus.load_ready = load_ready_c;
   assign bus.mux_data   = mux_data_q;
   assign bus.mux_sel    = sel_cnt;
   assign bus.bit_valid  = bit_valid_q;
   assign bus.bit_out    = bit_out_q;
   assign bus.done       = done_q;
   assign bus.match      = match_q;
   assign bus.cap_data   = cap_q;

endmodule

// File: tb/tb_mux_loopback_sequencer.sv
// Loopback bench: two sequencers (LSB-first and MSB-first) each wired to a behavioural
// 8-to-1 mux; expected bit stream and results are queued at load and popped on output.
module tb_mux_loopback_sequencer;

   typedef struct packed {
      logic [7:0] cap;
      logic       match;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic exp_bits0[$];
   logic exp_bits1[$];
   res_t exp_res0[$];
   res_t exp_res1[$];

   logic       force0     = 1'b0;
   logic [2:0] force_sel0 = 3'd0;

   mux_loopback_sequencer_if #(.DATA_W(8)) bus0 ();
   mux_loopback_sequencer_if #(.DATA_W(8)) bus1 ();

   mux_loopback_sequencer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.master)
   );

   mux_loopback_sequencer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.master)
   );

   // Behavioural 8-to-1 mux; instance 0 can have one input stuck at 0.
   assign bus0.mux_y = (force0 && (bus0.mux_sel == force_sel0)) ? 1'b0 : bus0.mux_data[bus0.mux_sel];
   assign bus1.mux_y = bus1.mux_data[bus1.mux_sel];

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitors: pop expected bits/results as the DUTs produce them.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus0.bit_valid) begin
            chk("bit0_expected", 32'(exp_bits0.size() != 0), 32'd1);
            if (exp_bits0.size() != 0) chk("bit0_out", 32'(bus0.bit_out), 32'(exp_bits0.pop_front()));
         end
         if (bus0.done) begin
            chk("done0_expected", 32'(exp_res0.size() != 0), 32'd1);
            if (exp_res0.size() != 0) chk("res0", {23'd0, bus0.cap_data, bus0.match}, 32'(exp_res0.pop_front()));
         end
         if (bus1.bit_valid) begin
            chk("bit1_expected", 32'(exp_bits1.size() != 0), 32'd1);
            if (exp_bits1.size() != 0) chk("bit1_out", 32'(bus1.bit_out), 32'(exp_bits1.pop_front()));
         end
         if (bus1.done) begin
            chk("done1_expected", 32'(exp_res1.size() != 0), 32'd1);
            if (exp_res1.size() != 0) chk("res1", {23'd0, bus1.cap_data, bus1.match}, 32'(exp_res1.pop_front()));
         end
      end
   end

   task automatic check_idle0(input string tag);
      chk({tag, "_ready"}, 32'(bus0.load_ready), 32'd1);
      chk({tag, "_sel"}, 32'(bus0.mux_sel), 32'd0);
      chk({tag, "_bv"}, 32'(bus0.bit_valid), 32'd0);
      chk({tag, "_done"}, 32'(bus0.done), 32'd0);
   endtask

   // Full LSB-first sequence, optionally with one mux input stuck at 0.
   task automatic run_seq0(input logic [7:0] d, input logic frc, input logic [2:0] fsel);
      logic [7:0] cap;
      cap = d;
      if (frc) cap[fsel] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits0.push_back(cap[i]);
      exp_res0.push_back({cap, (cap == d)});
      force0     = frc;
      force_sel0 = fsel;
      @(negedge clk);
      chk("seq0_ready", 32'(bus0.load_ready), 32'd1);
      bus0.load_valid = 1'b1;
      bus0.load_data  = d;
      @(negedge clk);
      bus0.load_valid = 1'b0;
      bus0.load_data  = 8'h00;
      for (int k = 0; k < 8; k++) begin
         chk("seq0_sel", 32'(bus0.mux_sel), 32'(k));
         chk("seq0_mux_data", 32'(bus0.mux_data), 32'(d));
         chk("seq0_not_ready", 32'(bus0.load_ready), 32'd0);
         @(negedge clk);
      end
      chk("seq0_done", 32'(bus0.done), 32'd1);
      chk("seq0_match", 32'(bus0.match), 32'(cap == d));
      chk("seq0_cap", 32'(bus0.cap_data), 32'(cap));
      @(negedge clk);
      check_idle0("seq0_after");
      force0 = 1'b0;
   endtask

   // Full MSB-first sequence on the second instance.
   task automatic run_seq1(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) exp_bits1.push_back(d[i]);
      exp_res1.push_back({d, 1'b1});
      @(negedge clk);
      bus1.load_valid = 1'b1;
      bus1.load_data  = d;
      @(negedge clk);
      bus1.load_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("seq1_sel", 32'(bus1.mux_sel), 32'(7 - k));
         @(negedge clk);
      end
      chk("seq1_done", 32'(bus1.done), 32'd1);
      chk("seq1_match", 32'(bus1.match), 32'd1);
      chk("seq1_cap", 32'(bus1.cap_data), 32'(d));
      @(negedge clk);
      chk("seq1_ready", 32'(bus1.load_ready), 32'd1);
      chk("seq1_sel_idle", 32'(bus1.mux_sel), 32'd0);
   endtask

   initial begin
      bus0.load_valid = 1'b0;
      bus0.load_data  = 8'h00;
      bus0.abort      = 1'b0;
      bus1.load_valid = 1'b0;
      bus1.load_data  = 8'h00;
      bus1.abort      = 1'b0;

      // 1. Reset state and idle hold.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mux_data", 32'(bus0.mux_data), 32'd0);
      chk("rst_cap", 32'(bus0.cap_data), 32'd0);
      chk("rst_bit_out", 32'(bus0.bit_out), 32'd0);
      chk("rst_match", 32'(bus0.match), 32'd0);
      check_idle0("rst");
      chk("rst1_sel", 32'(bus1.mux_sel), 32'd0);
      chk("rst1_ready", 32'(bus1.load_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("idle_sel_hold", 32'(bus0.mux_sel), 32'd0);

      // 2. Clean loopback of 8'hCA.
      run_seq0(8'hCA, 1'b0, 3'd0);

      // 3. Input D stuck at 0: 8'h5A returns 8'h52, no match.
      run_seq0(8'h5A, 1'b1, 3'd3);

      // 4. MSB-first loopback of 8'h81.
      run_seq1(8'h81);

      // 5. Abort on the last select; load_valid held during SHIFT is ignored.
      @(negedge clk);
      bus0.abort = 1'b1;
      @(negedge clk);
      bus0.abort = 1'b0;
      check_idle0("abort_idle");
      for (int i = 0; i < 7; i++) exp_bits0.push_back(logic'((8'hA5 >> i) & 8'h01));
      bus0.load_valid = 1'b1;
      bus0.load_data  = 8'hA5;
      @(negedge clk);
      bus0.load_data  = 8'hFF;
      for (int k = 0; k < 7; k++) begin
         chk("abort_sel", 32'(bus0.mux_sel), 32'(k));
         chk("abort_mux_data", 32'(bus0.mux_data), 32'hA5);
         @(negedge clk);
      end
      chk("abort_sel7", 32'(bus0.mux_sel), 32'd7);
      bus0.abort      = 1'b1;
      bus0.load_valid = 1'b0;
      @(negedge clk);
      bus0.abort = 1'b0;
      check_idle0("abort_after");
      chk("abort_cap_partial", 32'(bus0.cap_data), 32'h25);
      chk("abort_mux_data_kept", 32'(bus0.mux_data), 32'hA5);
      @(negedge clk);
      chk("abort_no_done", 32'(bus0.done), 32'd0);

      // 6. Async reset mid-sequence, then a full sequence afterwards.
      for (int i = 0; i < 4; i++) exp_bits0.push_back(logic'((8'h3C >> i) & 8'h01));
      bus0.load_valid = 1'b1;
      bus0.load_data  = 8'h3C;
      @(negedge clk);
      bus0.load_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_sel4", 32'(bus0.mux_sel), 32'd4);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_sel", 32'(bus0.mux_sel), 32'd0);
      chk("rst_mid_mux_data", 32'(bus0.mux_data), 32'd0);
      chk("rst_mid_bv", 32'(bus0.bit_valid), 32'd0);
      chk("rst_mid_bit_out", 32'(bus0.bit_out), 32'd0);
      chk("rst_mid_cap", 32'(bus0.cap_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_seq0(8'h96, 1'b0, 3'd0);

      repeat (2) @(negedge clk);
      chk("sb_bits0_empty", 32'(exp_bits0.size()), 32'd0);
      chk("sb_bits1_empty", 32'(exp_bits1.size()), 32'd0);
      chk("sb_res0_empty", 32'(exp_res0.size()), 32'd0);
      chk("sb_res1_empty", 32'(exp_res1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
